// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps one request outstanding to a
// variable-latency instruction memory, skid-buffers one word under stall and redirects on EX branches.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_pc4,
    input  logic [15:0] br_imm16,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_inst,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic [31:0] pc
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DISCARD} state_t;

    state_t      state;
    logic        skid_vld;
    logic [31:0] skid_inst;
    logic [31:0] br_target;
    logic [31:0] pc_plus4;
    logic        ifid_open;
    logic        rsp_keep;
    logic        to_ifid;
    logic        capture;
    logic        release_skid;
    logic        advance;
    logic        inflight;

    function automatic logic [31:0] branch_target(input logic [31:0] pc4,
                                                  input logic [15:0] imm);
        logic signed [31:0] offset;
        offset = 32'(signed'({imm, 2'b00}));
        return pc4 + $unsigned(offset);
    endfunction

    assign br_target    = branch_target(br_pc4, br_imm16);
    assign pc_plus4     = pc + 32'd4;
    assign imem_addr    = {pc[31:2], 2'b00};
    assign ifid_open    = !stall || !if_id_valid;
    assign rsp_keep     = !br_taken && (state == S_WAIT) && imem_rvalid;
    assign to_ifid      = rsp_keep && ifid_open;
    assign capture      = rsp_keep && !ifid_open;
    assign release_skid = !br_taken && (state == S_HOLD) && !stall;
    assign advance      = to_ifid || release_skid;

    // A request presented this cycle is taken by memory on this edge, so a
    // redirect here must still swallow its response before refetching.
    assign inflight = ((state == S_REQ) && imem_req) ||
                      (((state == S_WAIT) || (state == S_DISCARD)) && !imem_rvalid);

    // Fetch control: state, request strobe, PC and skid occupancy
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_REQ;
            imem_req <= 1'b0;
            pc       <= RESET_PC;
            skid_vld <= 1'b0;
        end else if (br_taken) begin
            pc       <= br_target;
            skid_vld <= 1'b0;
            state    <= inflight ? S_DISCARD : S_REQ;
            imem_req <= !inflight;
        end else begin
            if (advance)
                pc <= pc_plus4;
            if (capture)
                skid_vld <= 1'b1;
            else if (release_skid)
                skid_vld <= 1'b0;
            unique case (state)
                // imem_req is low here only straight out of reset
                S_REQ: begin
                    imem_req <= !imem_req;
                    if (imem_req)
                        state <= S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        state    <= ifid_open ? S_REQ : S_HOLD;
                        imem_req <= ifid_open;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        state    <= S_REQ;
                        imem_req <= 1'b1;
                    end
                end
                S_DISCARD: begin
                    if (imem_rvalid) begin
                        state    <= S_REQ;
                        imem_req <= 1'b1;
                    end
                end
                default: begin
                    state    <= S_REQ;
                    imem_req <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(negedge clk) begin
        if (capture)
            skid_inst <= imem_rdata;
    end

    // IF/ID register: decode consumes it every unstalled cycle, so an empty
    // cycle becomes a bubble rather than repeating the last instruction
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_id_inst  <= NOP_INST;
            if_id_pc4   <= '0;
            if_id_valid <= 1'b0;
        end else if (br_taken) begin
            if_id_inst  <= NOP_INST;
            if_id_valid <= 1'b0;
        end else if (advance) begin
            if_id_inst  <= to_ifid ? imem_rdata : skid_inst;
            if_id_pc4   <= pc_plus4;
            if_id_valid <= 1'b1;
        end else if (!stall) begin
            if_id_inst  <= NOP_INST;
            if_id_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: variable-latency memory, transaction-level model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_if_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, br_taken;
    logic [31:0] br_pc4;
    logic [15:0] br_imm16;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] if_id_inst, if_id_pc4, pc;
    logic        if_id_valid;

    int vectors = 0;
    int miscompares = 0;
    int lat_cfg;
    bit chk_en;

    if_fetch_stage #(.RESET_PC(RESET_PC), .NOP_INST(NOP)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .br_taken(br_taken),
        .br_pc4(br_pc4), .br_imm16(br_imm16), .imem_req(imem_req),
        .imem_addr(imem_addr), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_id_inst(if_id_inst), .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid),
        .pc(pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h2008_0005;
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    function automatic logic [31:0] tgt(input logic [31:0] p4, input logic [15:0] imm);
        return p4 + {{14{imm[15]}}, imm, 2'b00};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h, want %08h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Memory: a request seen in one cycle answers lat cycles later
    int          mem_cnt = 0;
    logic [31:0] mem_a = 32'h0;
    always @(posedge clk) begin
        if (!rst_n) begin
            mem_cnt = 0;
            imem_rvalid = 1'b0;
        end else begin
            imem_rvalid = 1'b0;
            if (mem_cnt > 0) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem_word(mem_a);
                end
            end
            if (imem_req) begin
                mem_cnt = (lat_cfg == 0) ? int'($urandom_range(1, 4)) : lat_cfg;
                mem_a   = imem_addr;
            end
        end
    end

    // Reference model in terms of transactions: an outstanding request, a
    // pending drop, one buffered word and the IF/ID contents.
    logic [31:0] m_pc, m_inst, m_pc4, m_buf;
    logic        m_valid, m_req, m_out, m_drop, m_buf_v, m_resp, m_keep;
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc = RESET_PC; m_inst = NOP; m_pc4 = 0; m_valid = 0; m_req = 0;
            m_out = 0; m_drop = 0; m_buf_v = 0; m_buf = 0; m_resp = 0; m_keep = 0;
        end else begin
            m_resp = m_out && imem_rvalid;
            m_keep = m_resp && !m_drop && !br_taken;
            if (m_resp) begin m_out = 0; m_drop = 0; end
            if (m_req) m_out = 1;
            if (br_taken) begin
                if (m_out) m_drop = 1;
                m_pc = tgt(br_pc4, br_imm16);
                m_buf_v = 0; m_inst = NOP; m_valid = 0;
            end else if (m_keep && (!stall || !m_valid)) begin
                m_inst = imem_rdata; m_pc4 = m_pc + 4; m_pc = m_pc + 4; m_valid = 1;
            end else if (m_keep) begin
                m_buf = imem_rdata; m_buf_v = 1;
            end else if (m_buf_v && !stall) begin
                m_inst = m_buf; m_pc4 = m_pc + 4; m_pc = m_pc + 4; m_valid = 1; m_buf_v = 0;
            end else if (!stall) begin
                m_inst = NOP; m_valid = 0;
            end
            m_req = !m_out && !m_buf_v;
        end
    end

    always @(posedge clk) begin
        if (chk_en && rst_n) begin
            chk("m_req", {31'b0, imem_req}, {31'b0, m_req});
            if (imem_req && m_req) chk("m_addr", imem_addr, {m_pc[31:2], 2'b00});
            chk("m_valid", {31'b0, if_id_valid}, {31'b0, m_valid});
            chk("m_inst", if_id_inst, m_inst);
            chk("m_pc4", if_id_pc4, m_pc4);
            chk("m_pc", pc, m_pc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running, want finished");
        $fatal(1);
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"}, {31'b0, imem_req}, 32'h0);
        chk({tag, "_valid"}, {31'b0, if_id_valid}, 32'h0);
        chk({tag, "_inst"}, if_id_inst, NOP);
        chk({tag, "_pc4"}, if_id_pc4, 32'h0);
        chk({tag, "_pc"}, pc, RESET_PC);
    endtask

    initial begin
        int  nreq;
        bit  got;
        rst_n = 1'b0; stall = 1'b0; br_taken = 1'b0; br_pc4 = 0; br_imm16 = 0;
        lat_cfg = 1; chk_en = 1'b0; nreq = 0;
        #2;
        chk_reset_outputs("reset");
        @(posedge clk); @(posedge clk);
        #2 rst_n = 1'b1; chk_en = 1'b1;

        // first fetch and straight-line run of 8 words
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            if (imem_req) nreq++;
            if (k == 1) begin
                chk("first_req", {31'b0, imem_req}, 32'h1);
                chk("first_addr", imem_addr, 32'h0);
            end
            if (k == 3) begin
                chk("first_valid", {31'b0, if_id_valid}, 32'h1);
                chk("first_inst", if_id_inst, 32'h2008_0005);
                chk("first_pc4", if_id_pc4, 32'h4);
                chk("second_addr", imem_addr, 32'h4);
            end
        end
        chk("req_per_8_words", nreq, 8);
        @(posedge clk);
        chk("run_last_pc4", if_id_pc4, 32'h20);
        chk("run_next_addr", imem_addr, 32'h20);

        // stall while the response to 0x20 is in flight
        stall = 1'b1;
        repeat (3) begin
            @(posedge clk);
            chk("stall_pc4", if_id_pc4, 32'h20);
            chk("stall_valid", {31'b0, if_id_valid}, 32'h1);
            chk("stall_no_req", {31'b0, imem_req}, 32'h0);
        end
        stall = 1'b0;
        @(posedge clk);
        chk("unstall_pc4", if_id_pc4, 32'h24);
        chk("unstall_inst", if_id_inst, mem_word(32'h20));
        chk("unstall_req", {31'b0, imem_req}, 32'h1);
        chk("unstall_addr", imem_addr, 32'h24);

        // backward branch to 0
        @(posedge clk);
        br_taken = 1'b1; br_pc4 = 32'h10; br_imm16 = 16'hFFFC;
        @(posedge clk);
        br_taken = 1'b0;
        chk("br_flush_valid", {31'b0, if_id_valid}, 32'h0);
        chk("br_pc", pc, 32'h0);
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (imem_req) begin got = 1'b1; break; end
            @(posedge clk);
        end
        chk("br_req_seen", {31'b0, got}, 32'h1);
        chk("br_req_addr", imem_addr, 32'h0);
        #1 lat_cfg = 3;

        // redirect while a 3-cycle response is pending
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            if (imem_req) begin got = 1'b1; break; end
        end
        chk("lat3_req_seen", {31'b0, got}, 32'h1);
        br_taken = 1'b1; br_pc4 = 32'h100; br_imm16 = 16'h0010;
        @(posedge clk);
        br_taken = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            if (if_id_valid) begin got = 1'b1; break; end
        end
        chk("lat3_valid_seen", {31'b0, got}, 32'h1);
        chk("lat3_pc4", if_id_pc4, 32'h144);
        chk("lat3_inst", if_id_inst, mem_word(32'h140));

        // redirect and stall together, with wrap-around target
        @(posedge clk);
        stall = 1'b1; br_taken = 1'b1; br_pc4 = 32'hFFFF_FFFC; br_imm16 = 16'h0001;
        @(posedge clk);
        br_taken = 1'b0;
        chk("brstall_valid", {31'b0, if_id_valid}, 32'h0);
        chk("brstall_inst", if_id_inst, NOP);
        chk("brstall_pc", pc, 32'h0);
        repeat (3) @(posedge clk);
        stall = 1'b0;

        // randomized traffic
        #1 lat_cfg = 0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            stall    = ($urandom_range(0, 9) < 3);
            br_taken = ($urandom_range(0, 19) == 0);
            br_pc4   = $urandom & 32'hFFFF_FFFC;
            br_imm16 = 16'($urandom);
        end
        @(posedge clk);
        stall = 1'b0; br_taken = 1'b0;
        #1 lat_cfg = 1;

        // async reset while a word sits in the skid buffer
        got = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            if (if_id_valid) begin got = 1'b1; break; end
        end
        chk("hold_valid_seen", {31'b0, got}, 32'h1);
        stall = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            if (m_buf_v) begin got = 1'b1; break; end
        end
        chk("hold_reached", {31'b0, got}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        @(posedge clk); @(posedge clk);
        #2 rst_n = 1'b1; stall = 1'b0;
        repeat (20) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
